main_mul_approx: RTL and testbench
==================================

// Module: main_mul_approx
// PURPOSE
//  Approximate 8x8 unsigned multiplier using Mitchell's logarithmic method.
//  Returns the approximate base-2 logarithm of the product a*b as a 4.7
//  fixed-point value, and flags the case where either operand is zero.
//  Two-stage pipeline for datapaths that trade exact products for area and
//  power; the consumer antilogs or compares in the log domain.
// PARAMETERS
//  (none) operand width is fixed at 8 b; result width is fixed at 11 b (4 integer + 7 fraction).
// PORTS
//  clk        in   1   rising-edge clock; single clock domain
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   a and b are sampled when high
//  a          in   8   unsigned operand A
//  b          in   8   unsigned operand B
//  out_valid  out  1   out and zero are valid (in_valid delayed 2 cycles)
//  out        out  11  approx log2(a*b): out[10:7] integer, out[6:0] fraction
//  zero       out  1   1 when a==0 or b==0 (out forced 0)
// BEHAVIOUR
//  - Interface decision: one clock; reset is asynchronous and active-low.
//  - Reset: all pipeline registers clear asynchronously; out=0, zero=0, out_valid=0.
//  - Per operand x (nonzero):
//    - k = index of the leading one (0..7), found by a priority encoder.
//    - f = bits below the leading one, left-aligned into 7 b: f = (x << (7-k))[6:0].
//    - x = 1 gives k=0, f=0.
//  - Stage 1 (first edge with in_valid=1): register ka, fa, kb, fb, zero_s1 = (a==0)|(b==0), v1=in_valid.
//  - Stage 2 (next edge):
//    - sum = {ka,7'b0} + {kb,7'b0} + fa + fb; 11-bit unsigned.
//    - Maximum value is 14 + 254/128 < 16, so sum never overflows.
//    - The fraction carry goes into the integer field (Mitchell: no correction term).
//    - out <= zero_s1 ? 0 : sum; zero <= zero_s1; out_valid <= v1.
//  - Latency is exactly 2 cycles. Fully pipelined: one new operand pair accepted per cycle.
//  - No backpressure.
//  - Each stage register loads only when its incoming valid is 1 and otherwise holds its value.
//  - out_valid is always loaded, so it pulses for exactly one cycle per accepted input.
//  - a=1, b=1 gives out=0 with zero=0. Consumers must use the zero flag to tell "product 1" from "product 0".
//  - Combinations of in_valid not set in a cycle produce no output event. Back-to-back inputs produce back-to-back outputs.
//  - Reset asserted mid-operation discards in-flight data; out_valid is low until 2 cycles after the first valid input following reset release.
// TESTING
//  - a=1, b=1 -> out=11'b00000000000, zero=0, out_valid high 2 cycles after in_valid.
//  - a=255, b=255 -> out=11'b11111111110 (15 + 126/128), zero=0.
//  - a=91, b=117 -> out=11'b11010100000 (fa=54, fb=106, carry; 13 + 32/128).
//  - a=151, b=130 -> out=11'b11100011001; a=127, b=127 -> out=11'b11011111100.
//  - a=53, b=0 -> out=0, zero=1; then a=0, b=0 -> zero=1.
//  - Streaming and reset:
//    - Drive all vectors above on consecutive cycles -> results appear in the same order, one per cycle.
//    - Assert rst_n low mid-stream -> outputs 0 immediately, and no stale out_valid after release.

Source files
------------

// File: rtl/main_mul_approx_if.sv
// Bundles the operand/result signals of main_mul_approx.
//   in_valid  : operands a/b are sampled when high (master -> slave)
//   a, b      : 8-bit unsigned operands               (master -> slave)
//   out_valid : out/zero valid, one-cycle pulse        (slave -> master)
//   out       : approx log2(a*b), 4.7 fixed point      (slave -> master)
//   zero      : a==0 or b==0, out forced to 0          (slave -> master)
interface main_mul_approx_if;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic [10:0] out;
    logic        zero;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  out,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output out,
        output zero
    );
endinterface

// File: rtl/main_mul_approx.sv
// Approximate 8x8 unsigned multiplier (Mitchell's logarithmic method).
// Produces approx log2(a*b) as an 11-bit 4.7 fixed-point value, two cycles
// after the operands are accepted. Fully pipelined, no backpressure.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : main_mul_approx_if.slave (in_valid, a, b, out_valid, out, zero)
module main_mul_approx (
    input logic                 clk,
    input logic                 rst_n,
    main_mul_approx_if.slave    bus
);

    // Leading-one position of x; 0 for x==0 or x==1.
    function automatic logic [2:0] lead_one(input logic [7:0] x);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) k = 3'(i);
        end
        return k;
    endfunction

    // Bits below the leading one, left-aligned into 7 bits.
    function automatic logic [6:0] mantissa(input logic [7:0] x, input logic [2:0] k);
        logic [7:0] sh;
        sh = x << (3'd7 - k);
        return sh[6:0];
    endfunction

    logic [2:0] ka_d, kb_d;
    logic [6:0] fa_d, fb_d;

    always_comb begin
        ka_d = lead_one(bus.a);
        kb_d = lead_one(bus.b);
        fa_d = mantissa(bus.a, ka_d);
        fb_d = mantissa(bus.b, kb_d);
    end

    // Stage 1 registers
    logic [2:0] ka_q, kb_q;
    logic [6:0] fa_q, fb_q;
    logic       zero_s1_q;
    logic       v1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ka_q      <= 3'd0;
            kb_q      <= 3'd0;
            fa_q      <= 7'd0;
            fb_q      <= 7'd0;
            zero_s1_q <= 1'b0;
            v1_q      <= 1'b0;
        end else begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                ka_q      <= ka_d;
                kb_q      <= kb_d;
                fa_q      <= fa_d;
                fb_q      <= fb_d;
                zero_s1_q <= (bus.a == 8'd0) | (bus.b == 8'd0);
            end
        end
    end

    // Fraction carry propagates into the integer field; max 2046 fits in 11 bits.
    logic [10:0] sum;

    always_comb begin
        sum = {1'b0, ka_q, 7'd0} + {1'b0, kb_q, 7'd0} + {4'd0, fa_q} + {4'd0, fb_q};
    end

    // Stage 2 registers
    logic [10:0] out_q;
    logic        zero_q;
    logic        out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 11'd0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_q  <= zero_s1_q ? 11'd0 : sum;
                zero_q <= zero_s1_q;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_main_mul_approx.sv
module tb_main_mul_approx;

    logic clk;
    logic rst_n;

    main_mul_approx_if bus ();

    main_mul_approx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [10:0] out;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [10:0] out;
        logic        zero;
    } exp_t;

    localparam int NumVec = 8;
    vec_t vecs [NumVec];
    exp_t sb_q [$];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [10:0] last_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    task automatic drive(input int i);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = vecs[i].a;
        bus.b        = vecs[i].b;
        e.out        = vecs[i].out;
        e.zero       = vecs[i].zero;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.a        = 8'hxx;
            bus.b        = 8'hxx;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out", 32'(bus.out), 32'(e.out));
                    check("zero", 32'(bus.zero), 32'(e.zero));
                    last_out = bus.out;
                end
            end
        end
    end

    initial begin
        // Hand-computed Mitchell results.
        vecs[0] = '{a: 8'd1,   b: 8'd1,   out: 11'b00000000000, zero: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd255, out: 11'b11111111110, zero: 1'b0};
        vecs[2] = '{a: 8'd91,  b: 8'd117, out: 11'b11010100000, zero: 1'b0};
        vecs[3] = '{a: 8'd151, b: 8'd130, out: 11'b11100011001, zero: 1'b0};
        vecs[4] = '{a: 8'd127, b: 8'd127, out: 11'b11011111100, zero: 1'b0};
        vecs[5] = '{a: 8'd53,  b: 8'd0,   out: 11'b00000000000, zero: 1'b1};
        vecs[6] = '{a: 8'd0,   b: 8'd0,   out: 11'b00000000000, zero: 1'b1};
        vecs[7] = '{a: 8'd2,   b: 8'd3,   out: 11'b00101000000, zero: 1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 8'd0;
        bus.b        = 8'd0;
        #1;
        check("reset_out", 32'(bus.out), 32'd0);
        check("reset_zero", 32'(bus.zero), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Isolated transactions with latency check.
        drive(0);
        idle(1);
        @(posedge clk); #1;
        check("latency_a1b1_valid", 32'(bus.out_valid), 32'd1);
        idle(3);
        drive(5);
        idle(3);

        // Back-to-back stream.
        for (int i = 0; i < NumVec; i++) drive(i);
        idle(4);
        check("hold_out", 32'(bus.out), 32'(last_out));
        check("hold_out_value", 32'(bus.out), 32'(vecs[NumVec-1].out));

        // Reset mid-stream: in-flight results must be discarded.
        for (int i = 1; i < 5; i++) drive(i);
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out", 32'(bus.out), 32'd0);
        check("midrst_zero", 32'(bus.zero), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        drive(2);
        drive(3);
        idle(1);

        // Bounded drain of outstanding results.
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
